// File: rtl/sobel_magnitude_pkg.sv
// Shared widths, types and arithmetic helpers for the Sobel magnitude pipeline.
package sobel_magnitude_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 12;
  localparam logic [PIX_W-1:0] SAT_LIMIT = 8'd255;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0]         mag_t;

  // One window column, top = oldest row, bot = current row.
  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } win_col_t;

  function automatic grad_t weighted_sum(input pix_t a, input pix_t b, input pix_t c);
    return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
  endfunction

  function automatic mag_t abs_mag(input grad_t g);
    grad_t neg;
    neg = -g;
    return g[GRAD_W-1] ? {1'b0, neg} : {1'b0, g};
  endfunction

  function automatic pix_t saturate(input mag_t m);
    return (m > mag_t'(SAT_LIMIT)) ? SAT_LIMIT : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_magnitude_line_buffer.sv
// One-line pixel store with a single address port and a registered read.
// The read is issued for the presented address; a write lands at the address presented one cycle earlier.
module sobel_magnitude_line_buffer
  import sobel_magnitude_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    addr_i,
  input  logic             we_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  pix_t          mem_q [DEPTH];
  logic [AW-1:0] wr_addr_q;
  pix_t          rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
    end else begin
      wr_addr_q <= addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_q] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_magnitude.sv
// Streaming 3x3 Sobel edge magnitude: two line buffers, a sliding window,
// gradient register stage and a saturating magnitude output stage.
module sobel_magnitude
  import sobel_magnitude_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel,
  input  logic             pixel_valid,
  output logic [PIX_W-1:0] data,
  output logic             data_valid,
  output logic             frame_end
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  pix_t     lb1_rd, lb2_rd;
  win_col_t win0_q, win1_q, cur;
  grad_t    gx, gy;
  logic     win_done, frame_last;

  logic     v1_q, fe1_q;
  grad_t    gx_q, gy_q;
  mag_t     mag;
  pix_t     data_q;
  logic     data_valid_q, frame_end_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Addressed with the next column so the previous rows are ready when that pixel arrives.
  sobel_magnitude_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_buffer1 (
    .clk     (clk),
    .rst_n   (reset),
    .addr_i  (col_d),
    .we_i    (pixel_valid),
    .wdata_i (pixel),
    .rdata_o (lb1_rd)
  );

  sobel_magnitude_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_line_buffer2 (
    .clk     (clk),
    .rst_n   (reset),
    .addr_i  (col_d),
    .we_i    (pixel_valid),
    .wdata_i (lb1_rd),
    .rdata_o (lb2_rd)
  );

  always_comb begin
    cur.top    = lb2_rd;
    cur.mid    = lb1_rd;
    cur.bot    = pixel;
    gx         = weighted_sum(cur.top, cur.mid, cur.bot)
               - weighted_sum(win0_q.top, win0_q.mid, win0_q.bot);
    gy         = weighted_sum(win0_q.bot, win1_q.bot, cur.bot)
               - weighted_sum(win0_q.top, win1_q.top, cur.top);
    win_done   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    frame_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win0_q <= '0;
      win1_q <= '0;
    end else if (pixel_valid) begin
      win0_q <= win1_q;
      win1_q <= cur;
    end else begin
      win0_q <= win0_q;
      win1_q <= win1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      fe1_q <= 1'b0;
      gx_q  <= '0;
      gy_q  <= '0;
    end else begin
      v1_q  <= pixel_valid && win_done;
      fe1_q <= pixel_valid && frame_last;
      if (pixel_valid && win_done) begin
        gx_q <= gx;
        gy_q <= gy;
      end else begin
        gx_q <= gx_q;
        gy_q <= gy_q;
      end
    end
  end

  assign mag = abs_mag(gx_q) + abs_mag(gy_q);

  // data keeps its last value between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      data_valid_q <= v1_q;
      frame_end_q  <= v1_q && fe1_q;
      if (v1_q) begin
        data_q <= saturate(mag);
      end else begin
        data_q <= data_q;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_end  = frame_end_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Directed bench for sobel_magnitude on an 8x6 image: expected outputs are
// hand-computed per pattern and matched in order, with latency and frame_end.
module tb_sobel_magnitude;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pixel = 8'd0;
  logic       pixel_valid = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_end;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   n_fe = 0;
  logic [7:0] last_data = 8'd0;

  sobel_magnitude #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .data        (data),
    .data_valid  (data_valid),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int want);
    n_total++;
    if (got == want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Pattern ids: 0 flat 100, 1 vertical edge, 2 horizontal edge, 3 flat 100 (gapped), 4 flat 50, 5 ramp.
  function automatic logic [7:0] pix_of(input int t, input int r, input int c);
    int v;
    case (t)
      1:       v = (c < 4) ? 0 : 200;
      2:       v = (r < 3) ? 0 : 10;
      4:       v = 50;
      5:       v = 100 + 10 * c - 20 * r;
      default: v = 100;
    endcase
    return 8'(v);
  endfunction

  // Expected output for the window completed by pixel (r, c).
  function automatic logic [7:0] exp_of(input int t, input int r, input int c);
    int v;
    case (t)
      1:       v = (c == 4 || c == 5) ? 255 : 0;
      2:       v = (r == 3 || r == 4) ? 40 : 0;
      5:       v = 240;
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic send_pixel(input int t, input int r, input int c, input bit gap);
    exp_t e;
    pixel       = pix_of(t, r, c);
    pixel_valid = 1'b1;
    if (r >= 2 && c >= 2) begin
      e.cyc = cyc + 2;
      e.d   = exp_of(t, r, c);
      e.fe  = (r == H - 1) && (c == W - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int t, input bit gap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pixel(t, r, c, gap);
      end
    end
  endtask

  task automatic drain(input string tag, input int want_outs, input int want_fe);
    repeat (6) @(posedge clk);
    #1;
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_outs"}, n_out, want_outs);
    check_eq({tag, "_fe"}, n_fe, want_fe);
    exp_q.delete();
    n_out = 0;
    n_fe  = 0;
  endtask

  // Output monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_data = 8'd0;
      end
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_dv", int'(data_valid), 0);
          last_data = data;
        end else begin
          e = exp_q.pop_front();
          check_eq("latency", cyc, e.cyc);
          check_eq("data", int'(data), int'(e.d));
          check_eq("frame_end", int'(frame_end), int'(e.fe));
          last_data = e.d;
        end
        n_out++;
        if (frame_end) begin
          n_fe++;
        end
      end else begin
        check_eq("data_hold", int'(data), int'(last_data));
        check_eq("fe_idle", int'(frame_end), 0);
      end
    end
  end

  initial begin
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_data", int'(data), 0);
    check_eq("rst_dv", int'(data_valid), 0);
    check_eq("rst_fe", int'(frame_end), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    send_frame(0, 1'b0);
    drain("flat", 24, 1);
    send_frame(1, 1'b0);
    drain("vedge", 24, 1);
    send_frame(2, 1'b0);
    drain("hedge", 24, 1);
    send_frame(5, 1'b0);
    drain("ramp", 24, 1);
    send_frame(3, 1'b1);
    drain("gapped", 24, 1);

    // Partial frame up to row 3 col 3, then reset with results still in flight.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!(r == 3 && c > 3)) begin
          send_pixel(1, r, c, 1'b0);
        end
      end
    end
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_eq("midrst_data", int'(data), 0);
    check_eq("midrst_dv", int'(data_valid), 0);
    check_eq("midrst_fe", int'(frame_end), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n_out = 0;
    n_fe  = 0;
    @(posedge clk);
    #1;
    send_frame(4, 1'b0);
    drain("after_rst", 24, 1);

    send_frame(1, 1'b0);
    send_frame(2, 1'b0);
    drain("b2b", 48, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
